// File: rtl/scoreboard_pkg.sv
// rtl/scoreboard_pkg.sv - shared types for the DE/EX issue scoreboard
package scoreboard_pkg;

    typedef logic [4:0] reg_addr_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t rd;
    } inflight_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } sb_state_e;

endpackage

// File: rtl/inflight_pipe.sv
// rtl/inflight_pipe.sv - DEPTH-stage shadow of EX/MEM/WB destination writes
module inflight_pipe
    import scoreboard_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      hold_i,
    input  inflight_t entry_i,
    output inflight_t retire_o,
    output logic      busy_o
);

    inflight_t stage_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else if (!hold_i) begin
            stage_q[0] <= entry_i;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign retire_o = stage_q[DEPTH-1];

    always_comb begin
        busy_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) busy_o = busy_o | stage_q[i].valid;
    end

endmodule

// File: rtl/pipeline_scoreboard.sv
// rtl/pipeline_scoreboard.sv - RAW scoreboard, memWait freeze and drain FSM; SCOREBOARD_PERF_EN adds stall counter
module pipeline_scoreboard
    import scoreboard_pkg::*;
#(
    parameter int NUM_REGS   = 32,
    parameter int DEPTH      = 3,
    parameter int PERF_CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issueValidDE,
    input  logic [4:0]            rs1AddrDE,
    input  logic [4:0]            rs2AddrDE,
    input  logic                  rs1UsedDE,
    input  logic                  rs2UsedDE,
    input  logic [4:0]            rdAddrDE,
    input  logic                  rdWriteEnDE,
    input  logic                  flushDE,
    input  logic                  memWait,
    input  logic                  drainReq,
    output logic                  stallIFDE,
    output logic                  bubbleEX,
    output logic                  drainDone,
    output logic [PERF_CNT_W-1:0] stallCycles
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_ONE = 1;

    logic [CW-1:0] cnt_q [NUM_REGS];
    logic [CW-1:0] cnt_d [NUM_REGS];
    sb_state_e     state_q, state_d;
    inflight_t     new_entry, retire;
    logic          pipe_busy, all_clear;
    logic          hazard, block, issue, de_live;

    assign de_live = issueValidDE & ~flushDE;
    assign hazard  = de_live &
                     ((rs1UsedDE & (rs1AddrDE != 5'd0) & (cnt_q[rs1AddrDE] != '0)) |
                      (rs2UsedDE & (rs2AddrDE != 5'd0) & (cnt_q[rs2AddrDE] != '0)));
    assign block   = (state_q == DRAIN);
    assign issue   = de_live & ~hazard & ~block & ~memWait;

    assign stallIFDE = ~rst & (memWait | (de_live & (hazard | block)));
    assign bubbleEX  = rst | (~memWait & ~issue);
    assign drainDone = ~rst & (state_q == DONE);

    assign new_entry.valid = issue & rdWriteEnDE & (rdAddrDE != 5'd0);
    assign new_entry.rd    = rdAddrDE;

    inflight_pipe #(.DEPTH(DEPTH)) u_pipe (
        .clk_i    (clk),
        .rst_i    (rst),
        .hold_i   (memWait),
        .entry_i  (new_entry),
        .retire_o (retire),
        .busy_o   (pipe_busy)
    );

    // Increment and decrement of the same register in one cycle cancel out.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (!memWait) begin
                if (new_entry.valid && new_entry.rd == reg_addr_t'(r)) cnt_d[r] = cnt_d[r] + CNT_ONE;
                if (retire.valid && retire.rd == reg_addr_t'(r))       cnt_d[r] = cnt_d[r] - CNT_ONE;
            end
        end
    end

    always_comb begin
        all_clear = ~pipe_busy;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (cnt_q[r] != '0) all_clear = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!memWait) begin
            case (state_q)
                IDLE:    if (drainReq) state_d = DRAIN;
                DRAIN:   if (all_clear) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
        end else begin
            state_q <= state_d;
            for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
        end
    end

`ifdef SCOREBOARD_PERF_EN
    logic [PERF_CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stallIFDE && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign stallCycles = stall_cnt_q;
`else
    assign stallCycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// tb/tb_pipeline_scoreboard.sv - self-checking bench for pipeline_scoreboard
module tb_pipeline_scoreboard;

    localparam int DEPTH = 3;
    localparam int PW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          issueValidDE = 0, rs1UsedDE = 0, rs2UsedDE = 0, rdWriteEnDE = 0;
    logic          flushDE = 0, memWait = 0, drainReq = 0;
    logic [4:0]    rs1AddrDE = 0, rs2AddrDE = 0, rdAddrDE = 0;
    logic          stallIFDE, bubbleEX, drainDone;
    logic [PW-1:0] stallCycles;

    int checks = 0;
    int errors = 0;

    // Reference: each in-flight write is a record {rd, cycles of life left}.
    int         life_q[$];
    logic [4:0] rd_q[$];
    int         drain_ph = 0;
    int         perf_m   = 0;
    logic       obs_stall, obs_bub, obs_done;

    always #5 clk = ~clk;

    pipeline_scoreboard #(.NUM_REGS(32), .DEPTH(DEPTH), .PERF_CNT_W(PW)) dut (
        .clk(clk), .rst(rst), .issueValidDE(issueValidDE),
        .rs1AddrDE(rs1AddrDE), .rs2AddrDE(rs2AddrDE),
        .rs1UsedDE(rs1UsedDE), .rs2UsedDE(rs2UsedDE),
        .rdAddrDE(rdAddrDE), .rdWriteEnDE(rdWriteEnDE),
        .flushDE(flushDE), .memWait(memWait), .drainReq(drainReq),
        .stallIFDE(stallIFDE), .bubbleEX(bubbleEX), .drainDone(drainDone),
        .stallCycles(stallCycles)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic pend(input logic [4:0] r);
        foreach (rd_q[i]) if (rd_q[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step(input logic v, input logic [4:0] a1, input logic u1,
                        input logic [4:0] a2, input logic u2, input logic [4:0] rd,
                        input logic we, input logic fl, input logic mw, input logic dr);
        logic haz, blk, iss, e_stall, e_bub, e_done;
        issueValidDE = v; rs1AddrDE = a1; rs1UsedDE = u1; rs2AddrDE = a2; rs2UsedDE = u2;
        rdAddrDE = rd; rdWriteEnDE = we; flushDE = fl; memWait = mw; drainReq = dr;
        @(negedge clk);
        haz = v & ~fl & ((u1 & (a1 != 0) & pend(a1)) | (u2 & (a2 != 0) & pend(a2)));
        blk = (drain_ph == 1);
        iss = v & ~fl & ~haz & ~blk & ~mw;
        e_stall = rst ? 1'b0 : (mw | (v & ~fl & (haz | blk)));
        e_bub   = rst ? 1'b1 : (~mw & ~iss);
        e_done  = rst ? 1'b0 : (drain_ph == 2);
        obs_stall = stallIFDE; obs_bub = bubbleEX; obs_done = drainDone;
        chk("stallIFDE", 32'(stallIFDE), 32'(e_stall));
        chk("bubbleEX", 32'(bubbleEX), 32'(e_bub));
        chk("drainDone", 32'(drainDone), 32'(e_done));
`ifdef SCOREBOARD_PERF_EN
        chk("stallCycles", 32'(stallCycles), 32'(perf_m));
`else
        chk("stallCycles", 32'(stallCycles), 32'd0);
`endif
        if (rst) begin
            life_q.delete(); rd_q.delete(); drain_ph = 0; perf_m = 0;
        end else begin
            if (e_stall && perf_m < (1 << PW) - 1) perf_m++;
            if (!mw) begin
                case (drain_ph)
                    0: if (dr) drain_ph = 1;
                    1: if (life_q.size() == 0) drain_ph = 2;
                    default: drain_ph = 0;
                endcase
                for (int i = life_q.size() - 1; i >= 0; i--) begin
                    life_q[i]--;
                    if (life_q[i] == 0) begin life_q.delete(i); rd_q.delete(i); end
                end
                if (iss && we && rd != 0) begin life_q.push_back(DEPTH); rd_q.push_back(rd); end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic wr(input logic [4:0] rd);
        step(1, 0, 0, 0, 0, rd, 1, 0, 0, 0);
    endtask
    task automatic rd1(input logic [4:0] a, input logic fl, input logic mw);
        step(1, a, 1, 0, 0, 0, 0, fl, mw, 0);
    endtask
    task automatic do_reset(input int n);
        rst = 1'b1; idle(n); rst = 1'b0;
    endtask

    initial begin
        logic [3:0] pat;
        do_reset(2);

        // producer x5 then dependent reader: stall cycles 1-3, issue cycle 4
        wr(5);
        for (int i = 0; i < 4; i++) begin rd1(5, 0, 0); pat[i] = obs_stall; end
        chk("raw_stall_pattern", 32'(pat), 32'b1000 ^ 32'b1111);
        idle(3);

        // x0 never tracked; unused rs2 ignored
        wr(0); rd1(0, 0, 0); chk("x0_no_stall", 32'(obs_stall), 0);
        wr(5); step(1, 0, 0, 5, 0, 0, 0, 0, 0, 0); chk("rs2_unused", 32'(obs_stall), 0);
        idle(3);

        // memWait freezes the count down
        wr(5);
        for (int i = 0; i < 4; i++) begin rd1(5, 0, 1); chk("memwait_bubble", 32'(obs_bub), 0); end
        for (int i = 0; i < 4; i++) begin rd1(5, 0, 0); pat[i] = obs_stall; end
        chk("memwait_resume", 32'(pat), 32'b0111);
        idle(3);

        // flush wins over hazard
        wr(7); rd1(7, 1, 0);
        chk("flush_stall", 32'(obs_stall), 0); chk("flush_bubble", 32'(obs_bub), 1);
        idle(3);

        // double write x6 then drain
        wr(6); wr(6);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); chk("drain_block", 32'(obs_stall), 1);
        for (int i = 0; i < 4; i++) begin idle(1); pat[i] = obs_done; end
        chk("drain_done_pattern", 32'(pat), 32'b0100);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); idle(1); chk("empty_drain_d1", 32'(obs_done), 0);
        idle(1); chk("empty_drain_d2", 32'(obs_done), 1);
        idle(1);

        // reset during drain: no drainDone
        wr(9); step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); idle(1);
        do_reset(1);
        for (int i = 0; i < 5; i++) begin idle(1); chk("no_done_after_rst", 32'(obs_done), 0); end

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom_range(0, 1) != 0,
                 5'($urandom_range(0, 7)), $urandom_range(0, 1) != 0, 5'($urandom_range(0, 7)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0);
            if ($urandom_range(0, 149) == 0) do_reset(1);
        end
        do_reset(1);

`ifdef SCOREBOARD_PERF_EN
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("perf_ten", 32'(stallCycles), 10);
        do_reset(1);
        chk("perf_reset", 32'(stallCycles), 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("perf_saturate", 32'(stallCycles), 15);
`else
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("perf_tied_zero", 32'(stallCycles), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
